mdu_ctrl: RTL and testbench

- Multiply/divide unit controller for the pipelined MIPS core, sitting in the E stage.
- Accepts mult/multu/div/divu/mthi/mtlo requests and models the fixed multi-cycle latency with a busy countdown.
- Owns the architectural HI/LO registers.
- Generates the stall request the hazard logic uses to freeze D when an MDU-class instruction would collide with an in-flight operation.

---
 rtl/mdu_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide controller.
// Computes the 64-bit result at issue, then models the fixed multi-cycle
// latency with a countdown before committing to the architectural HI/LO.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_is_md,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          load;
   logic          finish;

   // mult/multu/div/divu all have md_op[2] clear; mthi/mtlo/reserved have it set.
   logic          is_long;
   logic          is_signed;
   logic          is_div;

   logic [63:0]   mul_a, mul_b, product;
   logic [31:0]   rs_mag, rt_mag, dvd, dvs, q_mag, r_mag, quot, rem;
   logic [63:0]   res;
   logic          res_we;

   logic [31:0]   pend_hi_q, pend_lo_q;
   logic          pend_we_q;

   assign is_long   = ~md_op[2];
   assign is_signed = ~md_op[0];
   assign is_div    = md_op[1];

   assign busy  = (state_q == RUN);
   assign stall = d_is_md & (busy | (start & is_long));

   // Result datapath: one shared multiplier and one shared unsigned divider.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      mul_a  = '0;
      mul_b  = '0;
      rs_mag = '0;
      rt_mag = '0;
      dvd    = '0;
      dvs    = '0;
      q_mag  = '0;
      r_mag  = '0;
      quot   = '0;
      rem    = '0;
      res    = '0;
      res_we = 1'b0;

      // Sign-extending into 64 bits makes the low 64 bits of the product
      // correct for both the signed and the unsigned flavour.
      mul_a   = {{32{is_signed & rs_val[31]}}, rs_val};
      mul_b   = {{32{is_signed & rt_val[31]}}, rt_val};
      product = mul_a * mul_b;

      // Signed divide runs on magnitudes; 0x80000000 has magnitude 2^31,
      // which fits unsigned, so the -2^31 / -1 corner falls out naturally.
      rs_mag = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
      rt_mag = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
      dvd    = is_signed ? rs_mag : rs_val;
      dvs    = is_signed ? rt_mag : rt_val;
      if (dvs != 32'd0) begin
         q_mag = dvd / dvs;
         r_mag = dvd % dvs;
      end
      quot = (is_signed & (rs_val[31] ^ rt_val[31])) ? (~q_mag + 32'd1) : q_mag;
      rem  = (is_signed & rs_val[31]) ? (~r_mag + 32'd1) : r_mag;

      case (md_op)
         OP_MULT, OP_MULTU: begin
            res    = product;
            res_we = 1'b1;
         end
         OP_DIV, OP_DIVU: begin
            res    = {rem, quot};
            res_we = (rt_val != 32'd0);
         end
         default: begin
            res    = '0;
            res_we = 1'b0;
         end
      endcase
   end

   // Next-state logic: accept a long op in IDLE, count down in RUN.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      load    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && is_long) begin
               state_d = RUN;
               count_d = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
               load    = 1'b1;
            end
         end
         RUN: begin
            if (count_q == CW'(1)) begin
               state_d = IDLE;
               count_d = '0;
               finish  = 1'b1;
            end else begin
               count_d = count_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   // State register plus architectural HI/LO updates.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (finish) begin
            if (pend_we_q) begin
               hi <= pend_hi_q;
               lo <= pend_lo_q;
            end
         end else if (state_q == IDLE && start && md_op == OP_MTHI) begin
            hi <= rs_val;
         end else if (state_q == IDLE && start && md_op == OP_MTLO) begin
            lo <= rs_val;
         end
      end
   end

   // Pending result captured at issue and held until the countdown expires.
   always_ff @(posedge clk) begin
      // NOTE: pending registers have no reset; they are only consumed in RUN, which reset leaves.
      if (load) begin
         pend_hi_q <= res[63:32];
         pend_lo_q <= res[31:0];
         pend_we_q <= res_we;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized and directed checks of mdu_ctrl against a
// behavioural HI/LO model computed with plain 64-bit arithmetic.
module tb_mdu_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  md_op = '0;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        d_is_md = 1'b0;
   logic        busy, stall;
   logic [31:0] hi, lo;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;

   mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .md_op   (md_op),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .d_is_md (d_is_md),
      .busy    (busy),
      .stall   (stall),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: architectural effect of one instruction on HI/LO.
   task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sq, sr;
      longint unsigned up;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         OP_MULT: begin
            p = sa * sb;
            model_hi = p[63:32];
            model_lo = p[31:0];
         end
         OP_MULTU: begin
            up = longint'({32'b0, a}) * longint'({32'b0, b});
            p  = up;
            model_hi = p[63:32];
            model_lo = p[31:0];
         end
         OP_DIV: if (b != 0) begin
            sq = sa / sb;
            sr = sa % sb;
            p  = sq;
            model_lo = p[31:0];
            p  = sr;
            model_hi = p[31:0];
         end
         OP_DIVU: if (b != 0) begin
            model_lo = a / b;
            model_hi = a % b;
         end
         OP_MTHI: model_hi = a;
         OP_MTLO: model_lo = a;
         default: ;
      endcase
   endtask

   function automatic int op_latency(input logic [2:0] op);
      if (op == OP_MULT || op == OP_MULTU) return MULT_N;
      if (op == OP_DIV || op == OP_DIVU) return DIV_N;
      return 0;
   endfunction

   // Issue one instruction in the current cycle T and follow it to completion.
   // inject >= 0 asserts a spurious start at that busy-cycle index.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic d, input int inject, input string tag);
      int   n;
      int   exp_n;
      logic exp_stall;
      exp_n   = op_latency(op);
      start   = 1'b1;
      md_op   = op;
      rs_val  = a;
      rt_val  = b;
      d_is_md = d;
      #1;
      exp_stall = d && (exp_n != 0);
      checks++;
      if (stall !== exp_stall) begin
         errors++;
         $display("FAIL %s stall_at_issue: got %b expected %b", tag, stall, exp_stall);
      end
      step();
      start  = 1'b0;
      rs_val = $urandom;
      rt_val = $urandom;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         if (n == inject) begin
            start  = 1'b1;
            md_op  = 3'($urandom_range(0, 5));
            rs_val = $urandom;
            rt_val = $urandom;
         end
         #1;
         checks++;
         if (stall !== d || hi !== model_hi || lo !== model_lo) begin
            errors++;
            $display("FAIL %s in_flight[%0d]: stall=%b hi=%h lo=%h expected stall=%b hi=%h lo=%h",
                     tag, n, stall, hi, lo, d, model_hi, model_lo);
         end
         n++;
         step();
         start = 1'b0;
      end
      checks++;
      if (n != exp_n) begin
         errors++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", tag, n, exp_n);
      end
      model_apply(op, a, b);
      #1;
      checks++;
      if (hi !== model_hi || lo !== model_lo || busy !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL %s result: hi=%h lo=%h busy=%b stall=%b expected hi=%h lo=%h busy=0 stall=0",
                  tag, hi, lo, busy, stall, model_hi, model_lo);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      step();
      step();
      reset = 1'b0;
      model_hi = '0;
      model_lo = '0;
   endtask

   task automatic test_reset();
      d_is_md = 1'b1;
      do_reset();
      checks++;
      if (busy !== 1'b0 || stall !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: busy=%b stall=%b hi=%h lo=%h expected 0 0 0 0", busy, stall, hi, lo);
      end
   endtask

   task automatic test_mult();
      run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, -1, "mult");
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL mult_const: hi=%h lo=%h expected ffffffff fffffffe", hi, lo);
      end
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, -1, "multu");
      checks++;
      if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL multu_const: hi=%h lo=%h expected 00000001 fffffffe", hi, lo);
      end
   endtask

   task automatic test_div();
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, "div_neg");
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         errors++;
         $display("FAIL div_neg_const: hi=%h lo=%h expected ffffffff fffffffd", hi, lo);
      end
      run_op(OP_DIVU, 32'd7, 32'd2, 1'b0, -1, "divu");
      checks++;
      if (hi !== 32'd1 || lo !== 32'd3) begin
         errors++;
         $display("FAIL divu_const: hi=%h lo=%h expected 00000001 00000003", hi, lo);
      end
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, "div_ovf");
      checks++;
      if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
         errors++;
         $display("FAIL div_ovf_const: hi=%h lo=%h expected 00000000 80000000", hi, lo);
      end
   endtask

   task automatic test_mthi_mtlo();
      run_op(OP_MTHI, 32'h1234_5678, $urandom, 1'b0, -1, "mthi");
      run_op(OP_MTLO, 32'h9ABC_DEF0, $urandom, 1'b0, -1, "mtlo");
      checks++;
      if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
         errors++;
         $display("FAIL mthi_mtlo_const: hi=%h lo=%h expected 12345678 9abcdef0", hi, lo);
      end
      run_op(OP_DIV, $urandom, 32'd0, 1'b0, -1, "div_zero");
      run_op(OP_DIVU, $urandom, 32'd0, 1'b1, -1, "divu_zero");
      checks++;
      if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
         errors++;
         $display("FAIL div_zero_const: hi=%h lo=%h expected 12345678 9abcdef0", hi, lo);
      end
   endtask

   task automatic test_stall();
      run_op(OP_DIV, 32'd1000, 32'd7, 1'b1, -1, "stall_md");
      run_op(OP_DIV, 32'd1000, 32'd7, 1'b0, -1, "stall_nonmd");
      run_op(OP_MULTU, $urandom, $urandom, 1'b1, -1, "stall_mult");
      d_is_md = 1'b0;
   endtask

   task automatic test_reset_mid();
      run_op(OP_MTHI, 32'hA5A5_0001, 32'd0, 1'b0, -1, "pre_reset_hi");
      start  = 1'b1;
      md_op  = OP_DIV;
      rs_val = 32'd12345;
      rt_val = 32'd10;
      step();
      start = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_hi = '0;
      model_lo = '0;
      checks++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
      end
      for (int i = 0; i < 12; i++) step();
      checks++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         errors++;
         $display("FAIL reset_no_late_write: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
      end
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, -1, "post_reset_mult");
   endtask

   task automatic test_back_to_back();
      run_op(OP_MULT, 32'd123456, 32'd654321, 1'b1, 1, "busy_start_mult");
      run_op(OP_DIV, 32'hDEAD_BEEF, 32'd3, 1'b0, 4, "busy_start_div");
      run_op(OP_MULTU, 32'hCAFE_F00D, 32'h0BAD_CAFE, 1'b0, -1, "b2b_multu");
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 0 : -1, "random");
         if ($urandom_range(0, 2) == 0) step();
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
